// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared SCCB constants, FSM encoding and line-level helper
package ov7670_pkg;

  localparam logic [7:0]  SCCB_WRITE_ID = 8'h42;
  localparam logic [15:0] CFG_END       = 16'hFFFF;
  localparam logic [15:0] COM7_RESET    = 16'h1280;
  localparam logic [5:0]  CFG_IDX_MAX   = 6'd63;
  localparam logic [4:0]  LAST_BIT      = 5'd26;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_BITS    = 3'd3;
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic [2:0] S_GAP     = 3'd5;
  localparam logic [2:0] S_RSTWAIT = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  typedef struct packed {
    logic sioc;
    logic siod_oe;
  } sccb_line_t;

  // Bus levels for a given position inside a write; anything outside START/BITS/STOP idles the bus.
  function automatic sccb_line_t sccb_line(input logic [2:0] state, input logic [1:0] qtr,
                                           input logic bit_val, input logic dont_care);
    sccb_line_t l;
    l.sioc    = 1'b1;
    l.siod_oe = 1'b0;
    case (state)
      S_START: l.siod_oe = qtr[1];
      S_BITS: begin
        l.sioc    = qtr[1];
        l.siod_oe = ~bit_val & ~dont_care;
      end
      S_STOP: begin
        l.sioc    = (qtr != 2'd0);
        l.siod_oe = ~qtr[1];
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/ov7670_sccb_cfg_if.sv
// rtl/ov7670_sccb_cfg_if.sv - control and SCCB bus bundle of the camera configurator
interface ov7670_sccb_cfg_if;
  logic       start;
  logic       sioc;
  logic       siod_oe;
  logic       busy;
  logic       done;
  logic [5:0] cfg_idx;

  modport master (input start, output sioc, output siod_oe, output busy, output done, output cfg_idx);
  modport slave  (output start, input sioc, input siod_oe, input busy, input done, input cfg_idx);
endinterface

// File: rtl/ov7670_cfg_rom.sv
// rtl/ov7670_cfg_rom.sv - register/value table: soft reset, QVGA RGB565, QQVGA down-scaling
module ov7670_cfg_rom (
  input  logic [5:0]  addr_i,
  output logic [15:0] data_o
);
  import ov7670_pkg::*;

  always_comb begin
    case (addr_i)
      6'd0:    data_o = COM7_RESET;
      6'd1:    data_o = 16'h1214;
      6'd2:    data_o = 16'h40D0;
      6'd3:    data_o = 16'h1101;
      6'd4:    data_o = 16'h0C04;
      6'd5:    data_o = 16'h3E1A;
      6'd6:    data_o = 16'h7222;
      6'd7:    data_o = 16'h73F2;
      default: data_o = CFG_END;
    endcase
  end

endmodule

// File: rtl/ov7670_sccb_cfg.sv
// rtl/ov7670_sccb_cfg.sv - walks the config ROM and issues one 3-phase SCCB write per entry
module ov7670_sccb_cfg #(
  parameter int unsigned QUARTER  = 250,
  parameter int unsigned RST_WAIT = 100_000,
  parameter int unsigned GAP_Q    = 4
) (
  input logic               clk,
  input logic               rst,
  ov7670_sccb_cfg_if.master bus
);
  import ov7670_pkg::*;

  localparam int unsigned QCW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam int unsigned WCW = (RST_WAIT > 1) ? $clog2(RST_WAIT) : 1;
  localparam logic [QCW-1:0] Q_LAST   = QCW'(QUARTER - 1);
  localparam logic [WCW-1:0] W_LAST   = WCW'(RST_WAIT - 1);
  localparam logic [7:0]     GAP_LAST = 8'(GAP_Q - 1);

  logic [2:0]     state_q, state_d;
  logic [QCW-1:0] qcnt_q, qcnt_d;
  logic [7:0]     qtr_q, qtr_d;
  logic [4:0]     bit_q, bit_d;
  logic [26:0]    sh_q, sh_d;
  logic [5:0]     idx_q, idx_d;
  logic [15:0]    entry_q, entry_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           sioc_q, sioc_d;
  logic           oe_q, oe_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [15:0]    rom_data;
  logic           tick;
  logic [7:0]     qtr_last;
  logic [5:0]     idx_next;
  logic           dont_care_d;
  sccb_line_t     line_d;

  ov7670_cfg_rom u_rom (
    .addr_i (idx_q),
    .data_o (rom_data)
  );

  assign tick     = (qcnt_q == Q_LAST);
  assign qtr_last = (state_q == S_GAP) ? GAP_LAST : 8'd3;
  assign idx_next = (idx_q == CFG_IDX_MAX) ? idx_q : idx_q + 6'd1;

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    entry_d = entry_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          idx_d   = 6'd0;
        end
      end
      S_LOAD: begin
        qcnt_d  = '0;
        qtr_d   = 8'd0;
        bit_d   = 5'd0;
        entry_d = rom_data;
        sh_d    = {SCCB_WRITE_ID, 1'b0, rom_data[15:8], 1'b0, rom_data[7:0], 1'b0};
        // Index 63 is never transmitted: running off the table ends the sequence.
        if (rom_data == CFG_END || idx_q == CFG_IDX_MAX) state_d = S_DONE;
        else                                             state_d = S_START;
      end
      S_START, S_BITS, S_STOP, S_GAP: begin
        qcnt_d = tick ? '0 : qcnt_q + QCW'(1);
        if (tick) begin
          if (qtr_q == qtr_last) begin
            qtr_d = 8'd0;
            case (state_q)
              S_START: begin
                state_d = S_BITS;
                bit_d   = 5'd0;
              end
              S_BITS: begin
                if (bit_q == LAST_BIT) begin
                  state_d = S_STOP;
                end else begin
                  bit_d = bit_q + 5'd1;
                  sh_d  = {sh_q[25:0], 1'b0};
                end
              end
              S_STOP: state_d = S_GAP;
              default: begin
                if (entry_q == COM7_RESET) begin
                  state_d = S_RSTWAIT;
                  wait_d  = '0;
                end else begin
                  state_d = S_LOAD;
                  idx_d   = idx_next;
                end
              end
            endcase
          end else begin
            qtr_d = qtr_q + 8'd1;
          end
        end
      end
      default: begin
        wait_d = wait_q + WCW'(1);
        if (wait_q == W_LAST) begin
          wait_d  = '0;
          state_d = S_LOAD;
          idx_d   = idx_next;
        end
      end
    endcase
  end

  // Outputs are registered from the next position so every line change lands on a quarter edge.
  assign dont_care_d = (bit_d == 5'd8) || (bit_d == 5'd17) || (bit_d == LAST_BIT);
  assign line_d      = sccb_line(state_d, qtr_d[1:0], sh_d[26], dont_care_d);

  always_comb begin
    sioc_d = line_d.sioc;
    oe_d   = line_d.siod_oe;
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      qcnt_q  <= '0;
      qtr_q   <= 8'd0;
      bit_q   <= 5'd0;
      sh_q    <= '0;
      idx_q   <= 6'd0;
      entry_q <= 16'd0;
      wait_q  <= '0;
      sioc_q  <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      entry_q <= entry_d;
      wait_q  <= wait_d;
      sioc_q  <= sioc_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.sioc    = sioc_q;
  assign bus.siod_oe = oe_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.cfg_idx = idx_q;

endmodule

// File: tb/tb_ov7670_sccb_cfg.sv
// tb/tb_ov7670_sccb_cfg.sv - decodes the SCCB bus and scores each write against a table model
module tb_ov7670_sccb_cfg;

  localparam int QUARTER   = 4;
  localparam int RST_WAIT  = 20;
  localparam int GAP_Q     = 4;
  localparam int FRAME_CYC = 112 * QUARTER;
  localparam int GAP_CYC   = (4 + GAP_Q) * QUARTER + 1;

  typedef struct packed {
    logic [5:0]  idx;
    logic [15:0] entry;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ov7670_sccb_cfg_if bus ();

  ov7670_sccb_cfg #(.QUARTER(QUARTER), .RST_WAIT(RST_WAIT), .GAP_Q(GAP_Q)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  logic [15:0] rom_ref[64];
  int          n_frames = 0;
  int          activity = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: every entry from 0 up to the end marker, index 63 never sent.
  task automatic push_expected(output int n);
    n = 0;
    for (int i = 0; i < 63; i++) begin
      if (rom_ref[i] == 16'hFFFF) break;
      exp_q.push_back('{idx: 6'(i), entry: rom_ref[i]});
      n++;
    end
  endtask

  logic        prev_sioc = 1'b1;
  logic        prev_oe   = 1'b0;
  logic        in_frame  = 1'b0;
  logic        stop_valid = 1'b0;
  logic [26:0] frame;
  logic [5:0]  frame_idx;
  logic [15:0] last_entry;
  int          nbits, cyc = 0, t_start, t_stop;
  exp_t        e;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      in_frame   = 1'b0;
      stop_valid = 1'b0;
    end else begin
      if (bus.sioc !== prev_sioc || bus.siod_oe !== prev_oe) activity++;
      if (!bus.busy) stop_valid = 1'b0;
      if (prev_sioc && bus.sioc && !prev_oe && bus.siod_oe) begin
        if (stop_valid)
          check("gap_cycles", 32'(cyc - t_stop),
                32'(GAP_CYC + ((last_entry == 16'h1280) ? RST_WAIT : 0)));
        in_frame  = 1'b1;
        nbits     = 0;
        frame     = '0;
        t_start   = cyc;
        frame_idx = bus.cfg_idx;
      end else if (prev_sioc && bus.sioc && prev_oe && !bus.siod_oe) begin
        if (in_frame) begin
          check("frame_cycles", 32'(cyc - t_start), 32'(FRAME_CYC));
          check("frame_bits", 32'(nbits), 32'd27);
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_frame: got frame %0h expected none", frame);
          end else begin
            e = exp_q.pop_front();
            check("id_byte", 32'(frame[26:19]), 32'h42);
            check("reg_byte", 32'(frame[17:10]), 32'(e.entry[15:8]));
            check("val_byte", 32'(frame[8:1]), 32'(e.entry[7:0]));
            check("dont_care_bits", 32'({frame[18], frame[9], frame[0]}), 32'b111);
            check("cfg_idx_in_write", 32'(frame_idx), 32'(e.idx));
            last_entry = e.entry;
          end
          n_frames++;
          stop_valid = 1'b1;
          t_stop     = cyc;
        end
        in_frame = 1'b0;
      end else if (!prev_sioc && bus.sioc && in_frame && nbits < 27) begin
        frame[26-nbits] = ~bus.siod_oe;
        nbits++;
      end
    end
    prev_sioc = bus.sioc;
    prev_oe   = bus.siod_oe;
  end

  task automatic issue_start(output int n);
    @(posedge clk); #1 bus.start = 1'b1;
    push_expected(n);
    @(posedge clk); #1 bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("done_after_start", 32'(bus.done), 32'd0);
  endtask

  task automatic wait_done(input bit noise, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1 bus.start = 1'b0;
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (noise && $urandom_range(0, 99) == 0) bus.start = 1'b1;
    end
    bus.start = 1'b0;
    check("done_reached", 32'(ok), 32'd1);
  endtask

  task automatic check_run_end(input int nf0, input int n);
    check("done_high", 32'(bus.done), 32'd1);
    check("busy_low", 32'(bus.busy), 32'd0);
    check("frames_written", 32'(n_frames - nf0), 32'(n));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n, nf0, act0;
    bit ok;
    for (int i = 0; i < 64; i++) rom_ref[i] = 16'hFFFF;
    rom_ref[0] = 16'h1280; rom_ref[1] = 16'h1214; rom_ref[2] = 16'h40D0; rom_ref[3] = 16'h1101;
    rom_ref[4] = 16'h0C04; rom_ref[5] = 16'h3E1A; rom_ref[6] = 16'h7222; rom_ref[7] = 16'h73F2;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_sioc", 32'(bus.sioc), 32'd1);
    check("rst_siod_oe", 32'(bus.siod_oe), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_cfg_idx", 32'(bus.cfg_idx), 32'd0);

    @(posedge clk); #1 rst = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1 rst = 1'b0; bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("start_with_rst_ignored", 32'(bus.busy), 32'd0);

    nf0 = n_frames;
    issue_start(n);
    wait_done(1'b1, 20000);
    check_run_end(nf0, n);

    act0 = activity;
    repeat (1000) @(posedge clk);
    #1 check("idle_activity", 32'(activity - act0), 32'd0);
    check("idle_done_held", 32'(bus.done), 32'd1);
    check("idle_sioc", 32'(bus.sioc), 32'd1);

    issue_start(n);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (bus.cfg_idx == 6'd2 && bus.sioc == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("reached_entry2_bits", 32'(ok), 32'd1);
    repeat ($urandom_range(0, 400)) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    check("abort_sioc", 32'(bus.sioc), 32'd1);
    check("abort_siod_oe", 32'(bus.siod_oe), 32'd0);
    check("abort_cfg_idx", 32'(bus.cfg_idx), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);

    repeat (3) @(posedge clk);
    nf0 = n_frames;
    issue_start(n);
    wait_done(1'b1, 20000);
    check_run_end(nf0, n);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ov7670_sccb_cfg.md
OV7670_SCCB_CFG -- requirements
Module: ov7670_sccb_cfg

Interface
REQ-001 Parameter QUARTER, default 250, clk cycles per quarter SCCB bit period (100 MHz / 250 / 4 = 100 kHz SIOC).
REQ-002 Parameter RST_WAIT, default 100_000, clk cycles to wait after the soft-reset write (1 ms at 100 MHz).
REQ-003 Parameter GAP_Q, default 4, idle quarters between consecutive register writes.
REQ-004 clk  input  1  board clock, 100 MHz; the only clock in the block.
REQ-005 rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-006 start  input  1  single-cycle pulse; begins the configuration sequence; ignored while busy=1.
REQ-007 sioc  output  1  SCCB clock to camera, push-pull.
REQ-008 siod_oe  output  1  SCCB data drive enable; 1 = pull SIOD low, 0 = release (pulled high externally).
REQ-009 busy  output  1  high from the cycle after an accepted start until the cycle done rises.
REQ-010 done  output  1  high after the table completes; stays high until rst or a new start.
REQ-011 cfg_idx  output  6  index of the table entry currently being written.

Function
REQ-012 Shall write the register/value pairs of ROM sub-module ov7670_cfg_rom in index order, starting at 0, stopping at the first entry equal to 16'hFFFF (end marker, not transmitted).
REQ-013 Each write shall be a 3-phase SCCB write: ID byte 8'h42, register address, data; each byte MSB first, followed by one don't-care bit with siod_oe=0 (27 bit slots).
REQ-014 A quarter-tick counter shall count 0..QUARTER-1 and pulse on terminal count; all state and line changes occur only on that pulse.
REQ-015 Bit slot (4 quarters): q0 sioc=0 and siod_oe=~bit; q1 sioc=0; q2 sioc=1; q3 sioc=1.
REQ-016 START slot: q0-q1 sioc=1 siod_oe=0; q2-q3 sioc=1 siod_oe=1 (SIOD falls while SIOC high).
REQ-017 STOP slot: q0 sioc=0 siod_oe=1; q1 sioc=1 siod_oe=1; q2-q3 sioc=1 siod_oe=0 (SIOD rises while SIOC high).
REQ-018 One write = START + 27 bit slots + STOP = 116 quarters, then GAP_Q quarters with sioc=1, siod_oe=0.
REQ-019 FSM states: IDLE, LOAD, START, BITS, STOP, GAP, RSTWAIT, DONE.
REQ-020 IDLE->LOAD on start; LOAD reads ROM at cfg_idx (one cycle), ->DONE if end marker, else ->START.
REQ-021 START->BITS->STOP->GAP each on completion of its quarters; GAP->RSTWAIT if the written entry was {8'h12,8'h80}, else ->LOAD with cfg_idx+1.
REQ-022 RSTWAIT counts RST_WAIT clk cycles, then ->LOAD with cfg_idx+1.
REQ-023 DONE: done=1, busy=0; start in DONE clears done and restarts at index 0.
REQ-024 cfg_idx shall saturate at 63; reaching index 63 without an end marker shall behave as end marker.
REQ-025 A 27-bit shift register shall hold {8'h42,1'b0,addr,1'b0,data,1'b0}; bit slot counter 0..26.
REQ-026 start pulse coincident with rst is ignored.

Reset
REQ-027 On rst: state=IDLE, sioc=1, siod_oe=0, busy=0, done=0, cfg_idx=0, all counters 0.
REQ-028 rst mid-transaction shall abort immediately and release the bus on the next edge; no STOP is generated.

Structure
REQ-029 Shared package ov7670_pkg holds: SCCB_WRITE_ID 8'h42, CFG_END 16'hFFFF, COM7 reset pair {8'h12,8'h80}, state encoding.
REQ-030 Sub-module ov7670_cfg_rom: combinational 6-bit addr -> 16-bit {reg,val}; entry 0 = 16'h1280, then COM7=8'h14 (QVGA RGB), COM15=8'hD0 (RGB565), CLKRC, QQVGA scaling (160x120) entries, then CFG_END.
REQ-031 Outputs sioc and siod_oe registered; no combinational path from start to any output.

Verification
REQ-032 QUARTER=4, RST_WAIT=20, rst then start pulse -> busy=1 next cycle; first SIOD falling edge with sioc=1; first 9 sampled bits on sioc rising = 0100_0010_x.
REQ-033 Same setup, ROM entry 1 = 16'h1204 -> second transaction decodes ID 8'h42, addr 8'h12, data 8'h04; sioc high for 16 cycles between entries 1 and 2.
REQ-034 Entry 0 write -> gap between its STOP and next START = GAP_Q*4 + 20 + LOAD cycles (≥36); cfg_idx=1 during second write.
REQ-035 ROM with 3 entries plus end marker -> exactly 3 START and 3 STOP conditions; done=1, busy=0; done held for 1000 cycles with no bus activity.
REQ-036 rst asserted mid-BITS of entry 2 -> next cycle sioc=1, siod_oe=0, cfg_idx=0, busy=0; subsequent start restarts at entry 0.
REQ-037 start pulsed while busy=1 -> no effect; transaction count and timing identical to an undisturbed run.
